// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores on a req/ready bus, steers byte lanes,
// formats load data and stalls the pipeline until the access retires.
module mem_access_stage #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM_in,
    input  logic [31:0] WriteDataM_in,
    input  logic [2:0]  Funct3M_in,
    input  logic        MemReadM_in,
    input  logic        MemWriteM_in,
    input  logic [4:0]  RdM_in,
    input  logic [31:0] PCPlus4M_in,
    input  logic        RegWriteM_in,
    input  logic [1:0]  ResultSrcM_in,
    output logic [31:0] ALUResultM_out,
    output logic [31:0] ReadDataM_out,
    output logic [4:0]  RdM_out,
    output logic [31:0] PCPlus4M_out,
    output logic        RegWriteM_out,
    output logic [1:0]  ResultSrcM_out,
    output logic        StallM,
    output logic        FaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, read_data_q, cnt_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        we_q, fault_q;

    logic        access, is_load, legal, misaligned, start, req_fault, timeout;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request decode; a simultaneous read and write is treated as a load.
    always_comb begin
        access     = MemReadM_in | MemWriteM_in;
        is_load    = MemReadM_in;
        legal      = is_load ? (Funct3M_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (Funct3M_in inside {3'b000, 3'b001, 3'b010});
        misaligned = ((Funct3M_in[1:0] == 2'b01) && ALUResultM_in[0]) ||
                     ((Funct3M_in[1:0] == 2'b10) && (ALUResultM_in[1:0] != 2'b00));
        start      = access && legal && !misaligned;
        req_fault  = access && (!legal || misaligned);
        timeout    = (WAIT_LIMIT != 0) && (cnt_q == 32'(WAIT_LIMIT - 1));
    end

    always_comb begin
        unique case (Funct3M_in[1:0])
            2'b00: begin
                st_wdata = {4{WriteDataM_in[7:0]}};
                st_wstrb = 4'b0001 << ALUResultM_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{WriteDataM_in[15:0]}};
                st_wstrb = 4'b0011 << ALUResultM_in[1:0];
            end
            default: begin
                st_wdata = WriteDataM_in;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start)          state_d = StBusy;
                else if (req_fault) state_d = StDone;
            end
            StBusy:  if (mem_ready || timeout) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            read_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q   <= {ALUResultM_in[31:2], 2'b00};
                        we_q     <= !is_load;
                        wstrb_q  <= is_load ? 4'b0000 : st_wstrb;
                        wdata_q  <= st_wdata;
                        funct3_q <= Funct3M_in;
                        off_q    <= ALUResultM_in[1:0];
                        cnt_q    <= '0;
                        fault_q  <= 1'b0;
                    end else if (req_fault) begin
                        fault_q <= 1'b1;
                        if (is_load) read_data_q <= '0;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_ready) begin
                        if (!we_q) read_data_q <= ld_data;
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                        if (!we_q) read_data_q <= '0;
                    end
                end
                default: begin
                    fault_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        StallM         = !reset && (((state_q == StIdle) && access) || (state_q == StBusy));
        mem_req        = (state_q == StBusy);
        mem_we         = (state_q == StBusy) && we_q;
        mem_wstrb      = (state_q == StBusy) ? wstrb_q : 4'b0000;
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        FaultM         = (state_q == StDone) && fault_q;
        RegWriteM_out  = RegWriteM_in && !FaultM;
        ReadDataM_out  = read_data_q;
        ALUResultM_out = ALUResultM_in;
        RdM_out        = RdM_in;
        PCPlus4M_out   = PCPlus4M_in;
        ResultSrcM_out = ResultSrcM_in;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int unsigned WL = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_in, wd_in, pc_in;
    logic [2:0]  f3_in;
    logic        rd_in, wr_in, rw_in;
    logic [4:0]  rdst_in;
    logic [1:0]  rs_in;
    logic [31:0] alu_out, rdata_out, pc_out;
    logic [4:0]  rdst_out;
    logic        rw_out, stall, fault;
    logic [1:0]  rs_out;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd   = '0;

    always #5 clk = ~clk;

    mem_access_stage #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .ALUResultM_in(alu_in), .WriteDataM_in(wd_in), .Funct3M_in(f3_in),
        .MemReadM_in(rd_in), .MemWriteM_in(wr_in), .RdM_in(rdst_in),
        .PCPlus4M_in(pc_in), .RegWriteM_in(rw_in), .ResultSrcM_in(rs_in),
        .ALUResultM_out(alu_out), .ReadDataM_out(rdata_out), .RdM_out(rdst_out),
        .PCPlus4M_out(pc_out), .RegWriteM_out(rw_out), .ResultSrcM_out(rs_out),
        .StallM(stall), .FaultM(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input int o,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Drives one instruction and checks it cycle by cycle until it retires.
    // lat: index of the BUSY cycle that sees mem_ready (>= WL means never).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int lat, input logic rw);
        logic        access, is_load, legal, mis, tmo;
        int          nbytes, nbusy, o;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        access  = rd | wr;
        is_load = rd;
        o       = int'(addr[1:0]);
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal   = is_load ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
        mis     = (addr % nbytes) != 0;
        tmo     = lat >= int'(WL);
        nbusy   = tmo ? int'(WL) : lat + 1;
        e_strb  = is_load ? 4'd0 : (nbytes == 1) ? 4'(1 << o) : (nbytes == 2) ? 4'(3 << o) : 4'hF;
        e_wdata = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;

        @(posedge clk); #1;
        rd_in = rd; wr_in = wr; f3_in = f3; alu_in = addr; wd_in = wd; rw_in = rw;
        rdst_in = 5'($urandom); pc_in = $urandom; rs_in = 2'($urandom);
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        check_eq("alu_pass", alu_out, alu_in);
        check_eq("rd_pass", 32'(rdst_out), 32'(rdst_in));
        check_eq("pc_pass", pc_out, pc_in);
        check_eq("rsrc_pass", 32'(rs_out), 32'(rs_in));
        check_eq("issue_stall", 32'(stall), 32'(access));
        check_eq("issue_req", 32'(mem_req), 0);
        check_eq("issue_regwr", 32'(rw_out), 32'(rw));
        if (!access) begin
            check_eq("idle_rdata", rdata_out, exp_rd);
            return;
        end
        if (legal && !mis) begin
            for (int k = 0; k < nbusy; k++) begin
                @(posedge clk); #1;
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? rdata : $urandom;
                @(negedge clk);
                check_eq("busy_stall", 32'(stall), 1);
                check_eq("busy_req", 32'(mem_req), 1);
                check_eq("busy_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("busy_we", 32'(mem_we), 32'(!is_load));
                check_eq("busy_wstrb", 32'(mem_wstrb), 32'(e_strb));
                if (!is_load) check_eq("busy_wdata", mem_wdata, e_wdata);
                check_eq("busy_fault", 32'(fault), 0);
            end
            if (is_load) exp_rd = tmo ? 32'd0 : fmt_load(f3, o, rdata);
        end else begin
            tmo = 1'b1;
            if (is_load) exp_rd = '0;
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        check_eq("done_stall", 32'(stall), 0);
        check_eq("done_req", 32'(mem_req), 0);
        check_eq("done_fault", 32'(fault), 32'(tmo));
        check_eq("done_regwr", 32'(rw_out), 32'(rw && !tmo));
        check_eq("done_rdata", rdata_out, exp_rd);
    endtask

    initial begin
        reset = 1'b1;
        alu_in = '0; wd_in = '0; pc_in = '0; f3_in = '0; rd_in = 0; wr_in = 0; rw_in = 0;
        rdst_in = '0; rs_in = '0; mem_ready = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(mem_req), 0);
        check_eq("rst_we", 32'(mem_we), 0);
        check_eq("rst_wstrb", 32'(mem_wstrb), 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_rdata", rdata_out, 0);
        check_eq("rst_fault", 32'(fault), 0);
        check_eq("rst_stall", 32'(stall), 0);
        reset = 1'b0;

        // Directed scenarios.
        do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1);
        do_access(0, 1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0);
        do_access(1, 0, 3'd2, 32'h301, 32'h0, 32'h1234_5678, 0, 1);
        do_access(1, 0, 3'd5, 32'h402, 32'h0, 32'hF00D_0000, 5, 1);
        do_access(1, 0, 3'd2, 32'h500, 32'h0, 32'hDEAD_BEEF, 100, 1);
        do_access(1, 0, 3'd2, 32'h504, 32'h0, 32'hCAFE_F00D, 0, 1);
        do_access(0, 1, 3'd3, 32'h600, 32'h1, 32'h0, 0, 1);
        do_access(1, 1, 3'd4, 32'h701, 32'h0, 32'h00A5_5A00, 1, 1);

        // Asynchronous reset in the middle of a BUSY phase.
        @(posedge clk); #1;
        rd_in = 1; wr_in = 0; f3_in = 3'd2; alu_in = 32'h40; mem_ready = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_req", 32'(mem_req), 0);
        check_eq("midrst_stall", 32'(stall), 0);
        check_eq("midrst_rdata", rdata_out, 0);
        check_eq("midrst_addr", mem_addr, 0);
        exp_rd = '0;
        rd_in = 0;
        @(negedge clk);
        reset = 1'b0;
        do_access(0, 1, 3'd2, 32'h10, 32'h1357_9BDF, 32'h0, 2, 0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            logic       rd, wr;
            int         kind;
            kind = $urandom_range(0, 9);
            rd   = (kind == 1) || (kind >= 2 && kind < 6);
            wr   = (kind == 1) || (kind >= 6);
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                   (rd ? 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0)
                       : 3'($urandom_range(0, 2)));
            if (f3 == 3'd6) f3 = 3'd6;
            do_access(rd, wr, f3, $urandom, $urandom, $urandom,
                      $urandom_range(0, int'(WL) + 2), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
